ex_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline; sits directly downstream of the decode stage and upstream of the memory stage.
- Registers the decode-to-execute bus and computes the ALU result.
- Issues the data-SRAM request for loads and stores.
- Forwards its writeback candidate back to decode.
- Runs an iterative 32-cycle divider (div/divu) with HI/LO registers, covering mfhi/mflo/mthi/mtlo, and stalls the pipeline while it runs.

---
 rtl/ex_stage.sv | 217 +++++++++++++++++++++
 tb/tb_ex_stage.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline: operand select, ALU, data-SRAM
// request, HI/LO registers and a 32-step restoring divider that stalls EX.
module ex_stage #(
    parameter int ID_TO_EX_WD  = 159,
    parameter int EX_TO_MEM_WD = 76,
    parameter int DIV_STEPS    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [37:0]             ex_to_id_bus,
    output logic                    ex_is_load,
    output logic                    stallreq_for_ex,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    output logic [1:0]              o_div_state
);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    localparam logic [4:0] LAST_STEP = 5'(DIV_STEPS - 1);

    logic [ID_TO_EX_WD-1:0] r_bus;
    logic [31:0] r_hi, r_lo;
    div_state_t  r_state, w_next;
    logic [4:0]  r_cnt;
    logic [31:0] r_quo, r_rem, r_dvs;
    logic        r_neg_q, r_neg_r;

    logic        w_bubble, w_advance;
    logic [31:0] w_pc, w_inst, w_rdata1, w_rdata2;
    logic [11:0] w_alu_op;
    logic [2:0]  w_sel1;
    logic [3:0]  w_sel2;
    logic        w_ram_en, w_rf_we, w_sel_rf_res;
    logic [3:0]  w_ram_wen;
    logic [4:0]  w_rf_waddr;
    logic        w_is_r, w_is_mfhi, w_is_mflo, w_is_mthi, w_is_mtlo, w_is_div, w_div_signed;
    logic [31:0] w_src1, w_src2, w_alu, w_ex_result;
    logic [31:0] w_add, w_sub, w_slt, w_sltu, w_sll, w_srl, w_sra, w_lui;
    logic        w_neg_a, w_neg_b, w_stallreq;
    logic [31:0] w_mag_a, w_mag_b, w_quo_fix, w_rem_fix;
    logic [32:0] w_shift, w_diff;
    logic        w_ge;
    logic        w_unused;

    // EX is held when stall[2] is set; it takes a bubble when only EX stops.
    assign w_bubble  = stall[2] & ~stall[3];
    assign w_advance = ~stall[2];

    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            r_bus <= '0;
        end else if (w_advance) begin
            r_bus <= id_to_ex_bus;
        end
    end

    assign w_pc         = r_bus[158:127];
    assign w_inst       = r_bus[126:95];
    assign w_alu_op     = r_bus[94:83];
    assign w_sel1       = r_bus[82:80];
    assign w_sel2       = r_bus[79:76];
    assign w_ram_en     = r_bus[75];
    assign w_ram_wen    = r_bus[74:71];
    assign w_rf_we      = r_bus[70];
    assign w_rf_waddr   = r_bus[69:65];
    assign w_sel_rf_res = r_bus[64];
    assign w_rdata1     = r_bus[63:32];
    assign w_rdata2     = r_bus[31:0];

    assign w_is_r       = (w_inst[31:26] == 6'd0);
    assign w_is_mfhi    = w_is_r & (w_inst[5:0] == 6'h10);
    assign w_is_mthi    = w_is_r & (w_inst[5:0] == 6'h11);
    assign w_is_mflo    = w_is_r & (w_inst[5:0] == 6'h12);
    assign w_is_mtlo    = w_is_r & (w_inst[5:0] == 6'h13);
    assign w_div_signed = w_is_r & (w_inst[5:0] == 6'h1A);
    assign w_is_div     = w_div_signed | (w_is_r & (w_inst[5:0] == 6'h1B));

    assign w_src1 = ({32{w_sel1[0]}} & w_rdata1)
                  | ({32{w_sel1[1]}} & w_pc)
                  | ({32{w_sel1[2]}} & {27'b0, w_inst[10:6]});
    assign w_src2 = ({32{w_sel2[0]}} & w_rdata2)
                  | ({32{w_sel2[1]}} & {{16{w_inst[15]}}, w_inst[15:0]})
                  | ({32{w_sel2[2]}} & 32'd8)
                  | ({32{w_sel2[3]}} & {16'b0, w_inst[15:0]});

    assign w_add  = w_src1 + w_src2;
    assign w_sub  = w_src1 - w_src2;
    assign w_slt  = {31'b0, $signed(w_src1) < $signed(w_src2)};
    assign w_sltu = {31'b0, w_src1 < w_src2};
    assign w_sll  = w_src2 << w_src1[4:0];
    assign w_srl  = w_src2 >> w_src1[4:0];
    assign w_sra  = $signed(w_src2) >>> w_src1[4:0];
    assign w_lui  = {w_src2[15:0], 16'b0};

    assign w_alu = ({32{w_alu_op[11]}} & w_add)
                 | ({32{w_alu_op[10]}} & w_sub)
                 | ({32{w_alu_op[9]}}  & w_slt)
                 | ({32{w_alu_op[8]}}  & w_sltu)
                 | ({32{w_alu_op[7]}}  & (w_src1 & w_src2))
                 | ({32{w_alu_op[6]}}  & ~(w_src1 | w_src2))
                 | ({32{w_alu_op[5]}}  & (w_src1 | w_src2))
                 | ({32{w_alu_op[4]}}  & (w_src1 ^ w_src2))
                 | ({32{w_alu_op[3]}}  & w_sll)
                 | ({32{w_alu_op[2]}}  & w_srl)
                 | ({32{w_alu_op[1]}}  & w_sra)
                 | ({32{w_alu_op[0]}}  & w_lui);

    always_comb begin
        w_ex_result = w_alu;
        if (w_is_mfhi) begin
            w_ex_result = r_hi;
        end else if (w_is_mflo) begin
            w_ex_result = r_lo;
        end
    end

    // Divider operates on magnitudes; signs are reapplied when the result is consumed.
    assign w_neg_a   = w_div_signed & w_rdata1[31];
    assign w_neg_b   = w_div_signed & w_rdata2[31];
    assign w_mag_a   = w_neg_a ? (~w_rdata1 + 32'd1) : w_rdata1;
    assign w_mag_b   = w_neg_b ? (~w_rdata2 + 32'd1) : w_rdata2;
    assign w_shift   = {r_rem, r_quo[31]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_ge      = (w_shift >= {1'b0, r_dvs});
    assign w_quo_fix = r_neg_q ? (~r_quo + 32'd1) : r_quo;
    assign w_rem_fix = r_neg_r ? (~r_rem + 32'd1) : r_rem;

    always_comb begin
        w_next     = r_state;
        w_stallreq = 1'b0;
        unique case (r_state)
            DIV_IDLE: begin
                if (w_is_div) begin
                    w_stallreq = 1'b1;
                    if (!w_bubble) w_next = DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                w_stallreq = 1'b1;
                if (w_bubble) begin
                    w_next = DIV_IDLE;
                end else if (r_cnt == LAST_STEP) begin
                    w_next = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (w_bubble || w_advance) w_next = DIV_IDLE;
            end
            default: w_next = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DIV_IDLE;
            r_cnt   <= 5'd0;
            r_quo   <= 32'd0;
            r_rem   <= 32'd0;
            r_dvs   <= 32'd0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == DIV_IDLE && w_is_div) begin
                r_quo   <= w_mag_a;
                r_dvs   <= w_mag_b;
                r_rem   <= 32'd0;
                r_neg_q <= w_neg_a ^ w_neg_b;
                r_neg_r <= w_neg_a;
                r_cnt   <= 5'd0;
            end else if (r_state == DIV_BUSY) begin
                r_quo <= {r_quo[30:0], w_ge};
                r_rem <= w_ge ? w_diff[31:0] : w_shift[31:0];
                r_cnt <= r_cnt + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_advance) begin
            if (r_state == DIV_DONE) begin
                r_lo <= w_quo_fix;
                r_hi <= w_rem_fix;
            end else if (w_is_mthi) begin
                r_hi <= w_rdata1;
            end else if (w_is_mtlo) begin
                r_lo <= w_rdata1;
            end
        end
    end

    assign stallreq_for_ex = w_stallreq;
    assign o_div_state     = r_state;
    assign ex_is_load      = w_ram_en & ~|w_ram_wen;
    assign data_sram_en    = w_ram_en;
    assign data_sram_wen   = w_ram_wen;
    assign data_sram_addr  = w_ex_result;
    assign data_sram_wdata = w_rdata2;
    assign ex_to_mem_bus   = {w_pc, w_ram_en, w_ram_wen, w_sel_rf_res, w_rf_we, w_rf_waddr, w_ex_result};
    assign ex_to_id_bus    = {w_rf_we, w_rf_waddr, w_ex_result};

    assign w_unused = ^{stall[5:4], stall[1:0], w_inst[25:16], w_diff[32]};

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: table of ALU/memory vectors plus hand-written divider,
// HI/LO, bubble and reset sequences, all checked against a result queue.
module tb_ex_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic [158:0] id_to_ex_bus;
    logic [75:0]  ex_to_mem_bus;
    logic [37:0]  ex_to_id_bus;
    logic         ex_is_load;
    logic         stallreq_for_ex;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic [1:0]   o_div_state;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_to_ex_bus    (id_to_ex_bus),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .ex_to_id_bus    (ex_to_id_bus),
        .ex_is_load      (ex_is_load),
        .stallreq_for_ex (stallreq_for_ex),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .o_div_state     (o_div_state)
    );

    localparam logic [11:0] OP_ADD = 12'h800, OP_SUB = 12'h400, OP_SLT = 12'h200, OP_SLTU = 12'h100;
    localparam logic [11:0] OP_AND = 12'h080, OP_NOR = 12'h040, OP_OR = 12'h020, OP_XOR = 12'h010;
    localparam logic [11:0] OP_SLL = 12'h008, OP_SRL = 12'h004, OP_SRA = 12'h002, OP_LUI = 12'h001;
    localparam logic [2:0]  S1_RS = 3'b001, S1_PC = 3'b010, S1_SA = 3'b100;
    localparam logic [3:0]  S2_RT = 4'b0001, S2_SIMM = 4'b0010, S2_8 = 4'b0100, S2_ZIMM = 4'b1000;
    localparam logic [5:0]  ST_RUN = 6'b000000, ST_HOLD = 6'b001111, ST_BUBBLE = 6'b000111;
    localparam logic [1:0]  ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2;

    typedef struct {
        logic [158:0] bus;
        logic [31:0]  exp_result;
        logic         exp_load;
    } vec_t;

    vec_t        vecs[16];
    logic [31:0] exp_q[$];
    int          n_vec = 0;
    int          n_fail = 0;
    logic [31:0] model_hi, model_lo;

    function automatic logic [158:0] mk_bus(input logic [31:0] pc, input logic [31:0] inst,
                                            input logic [11:0] op, input logic [2:0] s1,
                                            input logic [3:0] s2, input logic ram_en,
                                            input logic [3:0] ram_wen, input logic we,
                                            input logic [4:0] waddr, input logic sel_res,
                                            input logic [31:0] r1, input logic [31:0] r2);
        return {pc, inst, op, s1, s2, ram_en, ram_wen, we, waddr, sel_res, r1, r2};
    endfunction

    function automatic vec_t mkv(input logic [158:0] bus, input logic [31:0] res, input logic ld);
        vec_t v;
        v.bus = bus;
        v.exp_result = res;
        v.exp_load = ld;
        return v;
    endfunction

    function automatic logic [158:0] div_bus(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        return mk_bus(32'hBFC0_0100, sgn ? 32'h0109_001A : 32'h0109_001B, 12'h0, 3'b0, 4'b0,
                      1'b0, 4'h0, 1'b0, 5'd0, 1'b0, a, b);
    endfunction

    function automatic logic [158:0] mthi_bus(input logic [31:0] v);
        return mk_bus(32'hBFC0_0200, 32'h0100_0011, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, v, 32'd0);
    endfunction

    function automatic logic [158:0] mtlo_bus(input logic [31:0] v);
        return mk_bus(32'hBFC0_0204, 32'h0100_0013, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, v, 32'd0);
    endfunction

    logic [158:0] mfhi_b, mflo_b;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_pop(input string name);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %0h", name, ex_to_mem_bus[31:0]);
        end else begin
            e = exp_q.pop_front();
            check(name, 128'(ex_to_mem_bus[31:0]), 128'(e));
        end
    endtask

    // Drive inputs at the falling edge, let one rising edge pass, return at the next falling edge.
    task automatic step(input logic [158:0] bus, input logic [5:0] st);
        id_to_ex_bus = bus;
        stall = st;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue a divide, model the stall controller for 33 cycles, then optionally hold DONE.
    task automatic run_div(input logic [158:0] dbus, input logic [158:0] nbus, input int hold);
        step(dbus, ST_RUN);
        for (int k = 0; k <= 32; k++) begin
            check($sformatf("stallreq T+%0d", k), 128'(stallreq_for_ex), 128'(1'b1));
            step(nbus, ST_HOLD);
        end
        check("stallreq T+33", 128'(stallreq_for_ex), 128'(1'b0));
        check("state DONE T+33", 128'(o_div_state), 128'(ST_DONE));
        for (int j = 0; j < hold; j++) begin
            step(nbus, ST_HOLD);
            check($sformatf("state DONE hold%0d", j), 128'(o_div_state), 128'(ST_DONE));
            check($sformatf("stallreq hold%0d", j), 128'(stallreq_for_ex), 128'(1'b0));
        end
    endtask

    initial begin
        logic [31:0] a, b, q, r, e;
        logic        sgn;
        logic [158:0] bus;

        mfhi_b = mk_bus(32'hBFC0_0104, 32'h0000_4010, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0, 32'd0, 32'd0);
        mflo_b = mk_bus(32'hBFC0_0108, 32'h0000_4012, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0, 32'd0, 32'd0);

        rst = 1'b1;
        stall = ST_RUN;
        id_to_ex_bus = '0;
        step('0, ST_RUN);
        step('0, ST_RUN);
        check("reset mem_bus", 128'(ex_to_mem_bus), 128'(0));
        check("reset id_bus", 128'(ex_to_id_bus), 128'(0));
        check("reset misc", 128'({ex_is_load, stallreq_for_ex, data_sram_en, data_sram_wen, o_div_state}), 128'(0));
        check("reset sram", 128'({data_sram_addr, data_sram_wdata}), 128'(0));
        rst = 1'b0;

        vecs[0]  = mkv(mk_bus(32'hBFC0_0000, 32'h3402_00FF, OP_OR,   S1_RS, S2_ZIMM, 1'b0, 4'h0, 1'b1, 5'd2,  1'b0, 32'h0000_1200, 32'h0), 32'h0000_12FF, 1'b0);
        vecs[1]  = mkv(mk_bus(32'hBFC0_0004, 32'hAC09_0010, OP_ADD,  S1_RS, S2_SIMM, 1'b1, 4'hF, 1'b0, 5'd0,  1'b0, 32'h8000_0000, 32'hDEAD_BEEF), 32'h8000_0010, 1'b0);
        vecs[2]  = mkv(mk_bus(32'hBFC0_0008, 32'h8C0A_FFFC, OP_ADD,  S1_RS, S2_SIMM, 1'b1, 4'h0, 1'b1, 5'd10, 1'b1, 32'h1000_0008, 32'h0), 32'h1000_0004, 1'b1);
        vecs[3]  = mkv(mk_bus(32'hBFC0_000C, 32'h0109_5823, OP_SUB,  S1_RS, S2_RT,   1'b0, 4'h0, 1'b1, 5'd11, 1'b0, 32'd5, 32'd7), 32'hFFFF_FFFE, 1'b0);
        vecs[4]  = mkv(mk_bus(32'hBFC0_0010, 32'h0109_582A, OP_SLT,  S1_RS, S2_RT,   1'b0, 4'h0, 1'b1, 5'd11, 1'b0, 32'hFFFF_FFFF, 32'd1), 32'd1, 1'b0);
        vecs[5]  = mkv(mk_bus(32'hBFC0_0014, 32'h0109_582B, OP_SLTU, S1_RS, S2_RT,   1'b0, 4'h0, 1'b1, 5'd11, 1'b0, 32'hFFFF_FFFF, 32'd1), 32'd0, 1'b0);
        vecs[6]  = mkv(mk_bus(32'hBFC0_0018, 32'h0109_5827, OP_NOR,  S1_RS, S2_RT,   1'b0, 4'h0, 1'b1, 5'd11, 1'b0, 32'h0F0F_0000, 32'h00FF_00FF), 32'hF000_FF00, 1'b0);
        vecs[7]  = mkv(mk_bus(32'hBFC0_001C, 32'h0109_5826, OP_XOR,  S1_RS, S2_RT,   1'b0, 4'h0, 1'b1, 5'd11, 1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F), 32'hF0F0_0F0F, 1'b0);
        vecs[8]  = mkv(mk_bus(32'hBFC0_0020, 32'h0009_5900, OP_SLL,  S1_SA, S2_RT,   1'b0, 4'h0, 1'b1, 5'd11, 1'b0, 32'hFFFF_FFFF, 32'h8000_0001), 32'h0000_0010, 1'b0);
        vecs[9]  = mkv(mk_bus(32'hBFC0_0024, 32'h0109_5807, OP_SRA,  S1_RS, S2_RT,   1'b0, 4'h0, 1'b1, 5'd11, 1'b0, 32'h0000_0024, 32'h8000_0000), 32'hF800_0000, 1'b0);
        vecs[10] = mkv(mk_bus(32'hBFC0_0028, 32'h0009_5FC2, OP_SRL,  S1_SA, S2_RT,   1'b0, 4'h0, 1'b1, 5'd11, 1'b0, 32'h0, 32'h8000_0000), 32'h0000_0001, 1'b0);
        vecs[11] = mkv(mk_bus(32'hBFC0_002C, 32'h3C0C_1234, OP_LUI,  S1_RS, S2_ZIMM, 1'b0, 4'h0, 1'b1, 5'd12, 1'b0, 32'h0000_AAAA, 32'h0), 32'h1234_0000, 1'b0);
        vecs[12] = mkv(mk_bus(32'hBFC0_0030, 32'h0109_5821, OP_ADD,  S1_RS, S2_RT,   1'b0, 4'h0, 1'b1, 5'd11, 1'b0, 32'hFFFF_FFFF, 32'd2), 32'd1, 1'b0);
        vecs[13] = mkv(mk_bus(32'hBFC0_0034, 32'h0C00_0000, OP_ADD,  S1_PC, S2_8,    1'b0, 4'h0, 1'b1, 5'd31, 1'b0, 32'h0, 32'h0), 32'hBFC0_003C, 1'b0);
        vecs[14] = mkv(mk_bus(32'hBFC0_0038, 32'h0109_5825, 12'h000, S1_RS, S2_RT,   1'b0, 4'h0, 1'b1, 5'd11, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0), 32'd0, 1'b0);
        vecs[15] = mkv(mk_bus(32'hBFC0_003C, 32'h0109_5824, OP_AND,  S1_RS, S2_RT,   1'b0, 4'h0, 1'b1, 5'd11, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00), 32'hF000_F000, 1'b0);

        for (int i = 0; i < 16; i++) begin
            bus = vecs[i].bus;
            exp_q.push_back(vecs[i].exp_result);
            step(bus, ST_RUN);
            e = exp_q[0];
            check_pop($sformatf("vec%0d ex_result", i));
            check($sformatf("vec%0d mem_bus", i), 128'(ex_to_mem_bus),
                  128'({bus[158:127], bus[75], bus[74:71], bus[64], bus[70], bus[69:65], e}));
            check($sformatf("vec%0d id_bus", i), 128'(ex_to_id_bus), 128'({bus[70], bus[69:65], e}));
            check($sformatf("vec%0d is_load", i), 128'(ex_is_load), 128'(vecs[i].exp_load));
            check($sformatf("vec%0d sram", i), 128'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}),
                  128'({bus[75], bus[74:71], e, bus[31:0]}));
        end

        // Hold keeps the old instruction; a bubble clears EX.
        exp_q.push_back(32'h0000_12FF);
        step(vecs[0].bus, ST_RUN);
        step(vecs[3].bus, ST_HOLD);
        check_pop("hold ex_result");
        step(vecs[3].bus, ST_BUBBLE);
        check("bubble mem_bus", 128'(ex_to_mem_bus), 128'(0));

        // mthi/mtlo followed immediately by mfhi/mflo.
        step(mthi_bus(32'h1111_2222), ST_RUN);
        exp_q.push_back(32'h1111_2222);
        step(mfhi_b, ST_RUN);
        check_pop("mthi->mfhi");
        step(mtlo_bus(32'h3333_4444), ST_RUN);
        exp_q.push_back(32'h3333_4444);
        step(mflo_b, ST_RUN);
        check_pop("mtlo->mflo");

        // Signed divide -7 / 2.
        exp_q.push_back(32'hFFFF_FFFD);
        exp_q.push_back(32'hFFFF_FFFF);
        run_div(div_bus(32'hFFFF_FFF9, 32'd2, 1'b1), mflo_b, 0);
        step(mflo_b, ST_RUN);
        check("state IDLE after div", 128'(o_div_state), 128'(ST_IDLE));
        check_pop("div -7/2 lo");
        step(mfhi_b, ST_RUN);
        check_pop("div -7/2 hi");

        // divu 100 / 0 with MEM stalled for three cycles after DONE.
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'd100);
        run_div(div_bus(32'd100, 32'd0, 1'b0), mflo_b, 3);
        step(mflo_b, ST_RUN);
        check_pop("divu 100/0 lo");
        step(mfhi_b, ST_RUN);
        check_pop("divu 100/0 hi");

        // Random divides against SystemVerilog's own truncating division.
        for (int n = 0; n < 4; n++) begin
            sgn = n[0];
            a = $urandom();
            if (a == 32'h8000_0000) a = 32'd1;
            b = $urandom_range(1, 50000);
            if (sgn && ($urandom_range(0, 1) == 1)) b = ~b + 32'd1;
            if (sgn) begin
                q = 32'($signed(a) / $signed(b));
                r = 32'($signed(a) % $signed(b));
            end else begin
                q = a / b;
                r = a % b;
            end
            model_lo = q;
            model_hi = r;
            exp_q.push_back(q);
            exp_q.push_back(r);
            run_div(div_bus(a, b, sgn), mflo_b, n);
            step(mflo_b, ST_RUN);
            check_pop($sformatf("rand div%0d lo a=%0h b=%0h s=%0d", n, a, b, sgn));
            step(mfhi_b, ST_RUN);
            check_pop($sformatf("rand div%0d hi", n));
        end

        // Bubble while BUSY abandons the divide and leaves HI/LO alone.
        step(div_bus(32'd20, 32'd3, 1'b1), ST_RUN);
        step(mflo_b, ST_HOLD);
        step(mflo_b, ST_HOLD);
        check("state BUSY pre-bubble", 128'(o_div_state), 128'(ST_BUSY));
        step(mflo_b, ST_BUBBLE);
        check("state IDLE post-bubble", 128'(o_div_state), 128'(ST_IDLE));
        check("stallreq post-bubble", 128'(stallreq_for_ex), 128'(1'b0));
        exp_q.push_back(model_lo);
        step(mflo_b, ST_RUN);
        check_pop("lo unchanged after bubble");
        exp_q.push_back(model_hi);
        step(mfhi_b, ST_RUN);
        check_pop("hi unchanged after bubble");

        // Reset in the middle of a divide.
        step(div_bus(32'd1000, 32'd7, 1'b0), ST_RUN);
        for (int k = 0; k < 10; k++) step(mflo_b, ST_HOLD);
        check("state BUSY pre-rst", 128'(o_div_state), 128'(ST_BUSY));
        rst = 1'b1;
        step(mflo_b, ST_RUN);
        rst = 1'b0;
        check("state IDLE post-rst", 128'(o_div_state), 128'(ST_IDLE));
        check("stallreq post-rst", 128'(stallreq_for_ex), 128'(1'b0));
        check("mem_bus post-rst", 128'(ex_to_mem_bus), 128'(0));
        exp_q.push_back(32'd0);
        step(mfhi_b, ST_RUN);
        check_pop("hi cleared by rst");
        exp_q.push_back(32'd0);
        step(mflo_b, ST_RUN);
        check_pop("lo cleared by rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
